// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: valid/ready command in, one-cycle response pulse out.
// Latency accept->rsp_valid is 3 edges + APB wait states; cmd_ready only in IDLE, response has no backpressure.
module apb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  assign cmd_ready = (state == IDLE);

  // Abort on the edge that would complete the Nth consecutive not-ready ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] != 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              paddr    <= cmd_addr;
              pwdata   <= cmd_wdata;
              pwrite   <= cmd_write;
              psel     <= 1'b1;
              wait_cnt <= '0;
              state    <= SETUP;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
          end else if (timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: main instance (timeout 16) plus a timeout-disabled instance.
module tb_apb_cmd_master;

  logic        pclk, presetn, presetn0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  logic        cmd0_valid, cmd0_ready, cmd0_write;
  logic [31:0] cmd0_addr, cmd0_wdata;
  logic        rsp0_valid, rsp0_err, rsp0_timeout;
  logic [31:0] rsp0_rdata, paddr0, pwdata0, prdata0;
  logic        pwrite0, psel0, penable0, pready0, pslverr0;

  int n_cmp, n_fail;

  apb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  apb_cmd_master #(.TIMEOUT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn0),
    .cmd_valid(cmd0_valid), .cmd_ready(cmd0_ready), .cmd_write(cmd0_write),
    .cmd_addr(cmd0_addr), .cmd_wdata(cmd0_wdata),
    .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err), .rsp_timeout(rsp0_timeout),
    .paddr(paddr0), .pwdata(pwdata0), .pwrite(pwrite0), .psel(psel0), .penable(penable0),
    .pready(pready0), .pslverr(pslverr0), .prdata(prdata0)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Slave for the main instance. Mode 0: pready registered one cycle into ACCESS,
  // mode 1: zero-wait, mode 2: never ready. Register toggles while the bus is idle.
  logic [1:0]  slv_mode;
  logic        pready_r;
  logic [31:0] slv_reg;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_r <= 1'b0;
      slv_reg  <= 32'hAAAA_AAAA;
    end else begin
      pready_r <= psel && penable && !pready_r;
      if (!psel)
        slv_reg <= (slv_reg == 32'hAAAA_AAAA) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      else if (penable && pready && pwrite && !pslverr)
        slv_reg <= pwdata;
    end
  end

  assign pready  = (slv_mode == 2'd0) ? pready_r :
                   (slv_mode == 2'd1) ? (psel && penable) : 1'b0;
  assign pslverr = pready && (paddr == 32'h10);
  assign prdata  = slv_reg;

  // Slave for the timeout-disabled instance: ready on the 41st ACCESS cycle.
  int acc0;
  always_ff @(posedge pclk or negedge presetn0) begin
    if (!presetn0) acc0 <= 0;
    else if (psel0 && penable0) acc0 <= acc0 + 1;
    else acc0 <= 0;
  end
  assign pready0  = psel0 && penable0 && (acc0 >= 40);
  assign pslverr0 = 1'b0;
  assign prdata0  = 32'hC0DE_0000;

  int          n_edges, n_setup, n_access, hold_bad;
  logic        r_vld, r_err, r_to, r_psel, r_pen;
  logic [31:0] r_rd, cap_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    n_edges = 1; n_setup = 0; n_access = 0; hold_bad = 0; r_vld = 1'b0; cap_rd = 32'hX;
    r_err = 1'b0; r_to = 1'b0; r_rd = 32'h0; r_psel = 1'b0; r_pen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        r_vld = 1'b1; r_err = rsp_err; r_to = rsp_timeout; r_rd = rsp_rdata;
        r_psel = psel; r_pen = penable;
        break;
      end
      if (psel && !penable) n_setup++;
      if (psel && penable) begin
        n_access++;
        if (pready) cap_rd = prdata;
      end
      if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== d))) hold_bad++;
      if (penable && !psel) hold_bad++;
      n_edges++;
    end
  endtask

  int rsp_seen;

  initial begin
    n_cmp = 0; n_fail = 0;
    presetn = 1'b0; presetn0 = 1'b0; slv_mode = 2'd0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd0_valid = 1'b0; cmd0_write = 1'b0; cmd0_addr = 32'h0; cmd0_wdata = 32'h0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1; presetn0 = 1'b1;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // Write through the registered-ready slave
    run_cmd(1'b1, 32'h0, 32'h1234_5678);
    chk("wr_vld", r_vld, 1);
    chk("wr_edges", n_edges, 4);
    chk("wr_setup", n_setup, 1);
    chk("wr_access", n_access, 2);
    chk("wr_err", r_err, 0);
    chk("wr_rdata", r_rd, 0);
    chk("wr_hold", hold_bad, 0);
    chk("wr_psel_at_rsp", {r_psel, r_pen}, 0);

    // Back-to-back read in the response cycle
    chk("rd_cmd_ready", cmd_ready, 1);
    run_cmd(1'b0, 32'h0, 32'h0);
    chk("rd_vld", r_vld, 1);
    chk("rd_edges", n_edges, 4);
    chk("rd_rdata", r_rd, cap_rd);
    chk("rd_rdata_pattern", (r_rd == 32'hAAAA_AAAA) || (r_rd == 32'h5555_5555), 1);
    chk("rd_err", r_err, 0);
    chk("rd_hold", hold_bad, 0);

    // Slave error on read
    @(negedge pclk);
    run_cmd(1'b0, 32'h10, 32'h0);
    chk("slverr_vld", r_vld, 1);
    chk("slverr_err", r_err, 1);
    chk("slverr_timeout", r_to, 0);
    chk("slverr_rdata", r_rd, 0);

    // Misaligned: rejected locally
    @(negedge pclk);
    run_cmd(1'b1, 32'h2, 32'hDEAD_BEEF);
    chk("mis_vld", r_vld, 1);
    chk("mis_edges", n_edges, 1);
    chk("mis_no_bus", n_setup + n_access, 0);
    chk("mis_err", r_err, 1);
    chk("mis_timeout", r_to, 0);
    chk("mis_rdata", r_rd, 0);
    @(negedge pclk);
    chk("mis_pulse_one_cycle", rsp_valid, 0);
    chk("mis_psel_idle", psel, 0);

    // Zero-wait slave
    slv_mode = 2'd1;
    run_cmd(1'b0, 32'h8, 32'h0);
    chk("zw_edges", n_edges, 3);
    chk("zw_access", n_access, 1);
    chk("zw_rdata", r_rd, cap_rd);

    // Stalled slave: timeout after 16 ACCESS cycles
    @(negedge pclk);
    slv_mode = 2'd2;
    run_cmd(1'b1, 32'h4, 32'h0BAD_F00D);
    chk("to_vld", r_vld, 1);
    chk("to_access", n_access, 16);
    chk("to_edges", n_edges, 18);
    chk("to_psel_at_rsp", r_psel, 0);
    chk("to_err", r_err, 1);
    chk("to_timeout", r_to, 1);
    chk("to_rdata", r_rd, 0);

    // Reset during ACCESS
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_mid_in_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    presetn = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) rsp_seen++;
    end
    chk("rst_mid_no_rsp", rsp_seen, 0);
    chk("rst_mid_ready_after", cmd_ready, 1);
    slv_mode = 2'd0;
    run_cmd(1'b1, 32'hC, 32'hCAFE_0001);
    chk("post_rst_edges", n_edges, 4);
    chk("post_rst_err", r_err, 0);

    // Timeout disabled: slave answers after 40 wait cycles
    chk("nt_cmd_ready", cmd0_ready, 1);
    cmd0_valid = 1'b1; cmd0_write = 1'b0; cmd0_addr = 32'h4;
    @(posedge pclk);
    #1 cmd0_valid = 1'b0;
    n_edges = 1; n_access = 0; r_vld = 1'b0; r_err = 1'b1; r_to = 1'b1; r_rd = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (rsp0_valid) begin
        r_vld = 1'b1; r_err = rsp0_err; r_to = rsp0_timeout; r_rd = rsp0_rdata;
        break;
      end
      if (psel0 && penable0) n_access++;
      n_edges++;
    end
    chk("nt_vld", r_vld, 1);
    chk("nt_access", n_access, 41);
    chk("nt_edges", n_edges, 43);
    chk("nt_err", r_err, 0);
    chk("nt_timeout", r_to, 0);
    chk("nt_rdata", r_rd, 32'hC0DE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB3 requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers. It drives `apb_slave` directly and returns a one-cycle response pulse carrying read data and error status. It adds wait-state handling, an access timeout, and local rejection of misaligned addresses before any bus activity.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles with `pready`=0 before abort; 0 disables the timeout.
- `pclk`  in  1  bus clock; all logic on rising edge.
- `presetn`  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  transfer failed: `pslverr`, timeout or misaligned.
- `rsp_timeout`  out  1  failure cause was timeout.
- `paddr`  out  32  APB address.
- `pwdata`  out  32  APB write data.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `prdata`  in  32  APB read data.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready`=1.
  - On accept with `cmd_addr[1:0]`≠0: no bus transfer; next cycle `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0; stay in IDLE.
  - On accept with an aligned address: register `paddr`/`pwdata`/`pwrite` from the command and go to SETUP.
- SETUP (exactly one cycle): `psel`=1, `penable`=0; then go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1.
  - Sample `pready` each edge. When it is 1, capture result and go to IDLE:
    - `rsp_err` = `pslverr`.
    - `rsp_rdata` = `prdata` if read and `pslverr`=0, else 0.
  - If `pready`=0, increment the wait counter.
  - If the counter reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES`≠0), abort: go to IDLE with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `pready` and timeout on the same edge: `pready` wins.
- Wait counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
  - Cleared on entry to SETUP.
- Bus hold rules:
  - `paddr`, `pwdata`, `pwrite` hold their value from SETUP through completion.
  - In IDLE they keep the last value (no toggling).
- Back-to-back commands: `rsp_valid` of transfer N and acceptance of command N+1 can occur in the same IDLE cycle.
- Response has no backpressure. The consumer must take it on the pulse.

## Timing
- Reset values (all outputs):
  - `cmd_ready`=1 (state IDLE).
  - `psel`=0, `penable`=0, `pwrite`=0.
  - `paddr`=0, `pwdata`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_timeout`=0, `rsp_rdata`=0.
- Cycle sequence (accept edge = T0):
  - T0→T1: SETUP.
  - T1→T2: ACCESS.
  - The first `pready` sample is at the end of T2.
  - If `pready` is sampled 1 at edge Tk, then in cycle Tk: `psel`=0, `penable`=0, `rsp_valid`=1.
- With `apb_slave` (`pready` registered one cycle into ACCESS): read or write completes in 2 ACCESS cycles, so accept-to-`rsp_valid` is 4 edges.
- Zero-wait slave: accept-to-`rsp_valid` is 3 edges.
- Timeout with `TIMEOUT_CYCLES`=N: abort after N consecutive ACCESS cycles with `pready`=0; `rsp_valid` asserts one cycle later.
- `presetn` asserted mid-transfer:
  - Immediately (asynchronously) `psel`/`penable` go to 0, state goes to IDLE, no response is generated.
  - The pending command is lost.
- `penable` is never 1 without `psel`=1. `psel`=1 with `penable`=0 lasts exactly one cycle per transfer.

## Test plan
- Write `cmd_addr`=0x0, `cmd_wdata`=0x1234_5678 to `apb_slave` → SETUP then ACCESS observed; `rsp_valid` 4 edges after accept; `rsp_err`=0; `rsp_rdata`=0.
- Read `cmd_addr`=0x0 immediately after the previous write; `apb_slave` register toggles between 0xAAAA_AAAA and 0x5555_5555 while idle → `rsp_rdata` equals the slave register value at the read edge; `rsp_err`=0.
- Read `cmd_addr`=0x10 → `pslverr`=1 at completion; `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- `cmd_addr`=0x2 → no `psel` pulse ever; `rsp_valid`, `rsp_err`=1 one cycle after accept.
- Stub slave holding `pready`=0 with `TIMEOUT_CYCLES`=16 → exactly 16 ACCESS cycles, then `psel`=0; `rsp_err`=1, `rsp_timeout`=1.
  - Repeat with `TIMEOUT_CYCLES`=0 and `pready` raised after 40 cycles → normal completion, no timeout.
- Assert `presetn`=0 during ACCESS → `psel`/`penable` fall without a clock edge; after release: no `rsp_valid`, `cmd_ready`=1, and the next command completes normally.
